// File: rtl/pma_link_ctrl.sv
// pma_link_ctrl: link-training and data-path sequencer between the MAC and the PMA
// parallel interface.
//
// On link_en_i it sends an alternating K28.5/D10.2 training pattern. It waits for the
// receiver to return comma/ID pairs, and corrects one lane polarity inversion per
// attempt. After LockCnt good pairs it declares link-up and passes MAC symbols through,
// with K28.5 idle fill. Loss of received commas or a retrain pulse sends it back to
// training.
//
// Optional build macro: PMA_LINK_STATS_EN adds retrain_count_o. This is a saturating
// count of LINK_UP->TRAIN transitions and of training timeouts.
//
// Ports:
//   bit_rate_clk_10_i  parallel symbol clock (sole clock)
//   rst_ni             asynchronous active-low reset
//   link_en_i          level, 1 = bring link up
//   retrain_i          pulse, force retraining from LINK_UP
//   mac_data_in_i      encoded MAC symbol
//   mac_valid_i        mac_data_in_i valid (honoured only while mac_ready_o = 1)
//   rx_data_i          PMA RX_Out symbol
//   tx_data_o          PMA Data_in symbol (registered)
//   mac_data_en_o      PMA MAC_Data_En (registered)
//   rx_polarity_o      PMA RxPolarity (registered)
//   link_up_o          link established
//   mac_ready_o        MAC symbol accepted this cycle
//   train_fail_o       one-cycle pulse on training timeout
//   retrain_count_o    (PMA_LINK_STATS_EN only) saturating retrain/fail count
//   state_o            0 = IDLE, 1 = TRAIN, 2 = LINK_UP
module pma_link_ctrl #(
  parameter int unsigned          DataWidth    = 10,
  parameter logic [DataWidth-1:0] CommaN       = 10'b0011111010,
  parameter logic [DataWidth-1:0] CommaP       = 10'b1100000101,
  parameter logic [DataWidth-1:0] TsId         = 10'b0101010101,
  parameter int unsigned          LockCnt      = 8,
  parameter int unsigned          TrainTimeout = 1024,
  parameter int unsigned          LosCnt       = 256,
  parameter int unsigned          PolSettle    = 4
) (
  input  logic                 bit_rate_clk_10_i,
  input  logic                 rst_ni,
  input  logic                 link_en_i,
  input  logic                 retrain_i,
  input  logic [DataWidth-1:0] mac_data_in_i,
  input  logic                 mac_valid_i,
  input  logic [DataWidth-1:0] rx_data_i,
  output logic [DataWidth-1:0] tx_data_o,
  output logic                 mac_data_en_o,
  output logic                 rx_polarity_o,
  output logic                 link_up_o,
  output logic                 mac_ready_o,
  output logic                 train_fail_o,
`ifdef PMA_LINK_STATS_EN
  output logic [7:0]           retrain_count_o,
`endif
  output logic [1:0]           state_o
);

  localparam int unsigned TimeoutW = $clog2(TrainTimeout);
  localparam int unsigned GoodW    = $clog2(LockCnt + 1);
  localparam int unsigned SettleW  = $clog2(PolSettle + 1);
  localparam int unsigned LosW     = $clog2(LosCnt + 1);

  localparam logic [TimeoutW-1:0] TimeoutMax = TimeoutW'(TrainTimeout - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTrain  = 2'd1,
    StLinkUp = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  tx_q, tx_d;
  logic                  mac_en_q, mac_en_d;
  logic                  pol_q, pol_d;
  logic                  link_up_q, link_up_d;
  logic                  mac_ready_q, mac_ready_d;
  logic                  fail_q, fail_d;
  logic                  phase_q, phase_d;     // 1 = next training symbol is TsId
  logic                  flip_q, flip_d;       // polarity flip already used this attempt
  logic [GoodW-1:0]      good_q, good_d;
  logic [SettleW-1:0]    settle_q, settle_d;
  logic [TimeoutW-1:0]   timeout_q, timeout_d;
  logic [LosW-1:0]       los_q, los_d, los_next;
  logic                  prev_comma_q;
  logic                  comma;
  logic                  restart;              // (re)enter TRAIN with a fresh attempt
  logic                  go_idle;

  assign comma = (rx_data_i == CommaN) || (rx_data_i == CommaP);

  always_comb begin
    state_d     = state_q;
    tx_d        = '0;
    mac_en_d    = 1'b0;
    pol_d       = pol_q;
    link_up_d   = 1'b0;
    mac_ready_d = 1'b0;
    fail_d      = 1'b0;
    phase_d     = phase_q;
    flip_d      = flip_q;
    good_d      = good_q;
    settle_d    = settle_q;
    timeout_d   = timeout_q;
    los_d       = '0;
    los_next    = comma ? '0 : los_q + 1'b1;
    restart     = 1'b0;
    go_idle     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (link_en_i) restart = 1'b1;
      end

      StTrain: begin
        if (!link_en_i) begin
          go_idle = 1'b1;
        end else if (good_q == GoodW'(LockCnt)) begin
          // Lock beats a coincident timeout.
          state_d     = StLinkUp;
          link_up_d   = 1'b1;
          mac_ready_d = 1'b1;
          mac_en_d    = 1'b1;
          tx_d        = CommaN;
        end else if (timeout_q == TimeoutMax) begin
          restart = 1'b1;
          fail_d  = 1'b1;
        end else begin
          mac_en_d  = 1'b1;
          tx_d      = phase_q ? TsId : CommaN;
          phase_d   = ~phase_q;
          timeout_d = timeout_q + 1'b1;
          // Pair check: a comma followed by the ID symbol is one good pair.
          if (settle_q != '0) begin
            settle_d = settle_q - 1'b1;
          end else if (prev_comma_q) begin
            if (rx_data_i == TsId) begin
              good_d = good_q + 1'b1;
            end else if (rx_data_i == ~TsId) begin
              good_d = '0;
              if (!flip_q) begin
                pol_d    = ~pol_q;
                flip_d   = 1'b1;
                settle_d = SettleW'(PolSettle);
              end
            end else begin
              good_d = '0;
            end
          end else if (!comma) begin
            good_d = '0;
          end
        end
      end

      StLinkUp: begin
        if (!link_en_i) begin
          go_idle = 1'b1;
        end else if (retrain_i || (los_next == LosW'(LosCnt))) begin
          restart = 1'b1;
        end else begin
          link_up_d   = 1'b1;
          mac_ready_d = 1'b1;
          mac_en_d    = 1'b1;
          los_d       = los_next;
          tx_d        = (mac_ready_q && mac_valid_i) ? mac_data_in_i : CommaN;
        end
      end

      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d   = StIdle;
      pol_d     = 1'b0;
      phase_d   = 1'b0;
      flip_d    = 1'b0;
      good_d    = '0;
      settle_d  = '0;
      timeout_d = '0;
    end

    if (restart) begin
      state_d   = StTrain;
      tx_d      = CommaN;
      mac_en_d  = 1'b1;
      pol_d     = 1'b0;
      phase_d   = 1'b1;
      flip_d    = 1'b0;
      good_d    = '0;
      settle_d  = '0;
      timeout_d = '0;
    end
  end

  always_ff @(posedge bit_rate_clk_10_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tx_q         <= '0;
      mac_en_q     <= 1'b0;
      pol_q        <= 1'b0;
      link_up_q    <= 1'b0;
      mac_ready_q  <= 1'b0;
      fail_q       <= 1'b0;
      phase_q      <= 1'b0;
      flip_q       <= 1'b0;
      good_q       <= '0;
      settle_q     <= '0;
      timeout_q    <= '0;
      los_q        <= '0;
      prev_comma_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      mac_en_q     <= mac_en_d;
      pol_q        <= pol_d;
      link_up_q    <= link_up_d;
      mac_ready_q  <= mac_ready_d;
      fail_q       <= fail_d;
      phase_q      <= phase_d;
      flip_q       <= flip_d;
      good_q       <= good_d;
      settle_q     <= settle_d;
      timeout_q    <= timeout_d;
      los_q        <= los_d;
      prev_comma_q <= comma;
    end
  end

`ifdef PMA_LINK_STATS_EN
  logic [7:0] retrain_cnt_q;

  // A restart out of TRAIN is a timeout; out of LINK_UP it is a retrain.
  always_ff @(posedge bit_rate_clk_10_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retrain_cnt_q <= '0;
    end else if (restart && (state_q != StIdle) && (retrain_cnt_q != 8'hFF)) begin
      retrain_cnt_q <= retrain_cnt_q + 8'd1;
    end
  end

  assign retrain_count_o = retrain_cnt_q;
`endif

  assign tx_data_o     = tx_q;
  assign mac_data_en_o = mac_en_q;
  assign rx_polarity_o = pol_q;
  assign link_up_o     = link_up_q;
  assign mac_ready_o   = mac_ready_q;
  assign train_fail_o  = fail_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pma_link_ctrl.sv
// Directed bench for pma_link_ctrl: normal and inverted loopback training, MAC
// pass-through and idle fill, retrain, loss of sync, training timeout, async reset.
module tb_pma_link_ctrl;

  localparam logic [9:0] CN = 10'h0FA;
  localparam logic [9:0] TS = 10'h155;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       link_en;
  logic       retrain;
  logic [9:0] mac_data;
  logic       mac_valid;
  logic [9:0] rx;
  logic [9:0] tx;
  logic       mac_en;
  logic       pol;
  logic       link_up;
  logic       ready;
  logic       fail;
  logic [1:0] state;
`ifdef PMA_LINK_STATS_EN
  logic [7:0] rc;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Loopback model: rx(n) = tx(n-3), inverted when the lane is flipped and uncorrected.
  logic [9:0] dl0, dl1, dl2;
  logic       loop_on, loop_inv;

  always #5 clk = ~clk;

  pma_link_ctrl dut (
    .bit_rate_clk_10_i (clk),
    .rst_ni            (rst_n),
    .link_en_i         (link_en),
    .retrain_i         (retrain),
    .mac_data_in_i     (mac_data),
    .mac_valid_i       (mac_valid),
    .rx_data_i         (rx),
    .tx_data_o         (tx),
    .mac_data_en_o     (mac_en),
    .rx_polarity_o     (pol),
    .link_up_o         (link_up),
    .mac_ready_o       (ready),
    .train_fail_o      (fail),
`ifdef PMA_LINK_STATS_EN
    .retrain_count_o   (rc),
`endif
    .state_o           (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (loop_on) rx = (loop_inv ^ pol) ? ~dl2 : dl2;
    dl2 = dl1;
    dl1 = dl0;
    dl0 = tx;
  endtask

  // Start from IDLE, enable the link over a loopback and check the lock point.
  task automatic run_lock(input logic inv);
    int lock_at;
    lock_at  = inv ? 27 : 21;
    dl0      = '0;
    dl1      = '0;
    dl2      = '0;
    rx       = '0;
    loop_inv = inv;
    loop_on  = 1'b1;
    link_en  = 1'b1;
    for (int n = 1; n <= lock_at; n++) begin
      tick();
      if (n == 1) begin
        check("train_state", 32'(state), 32'd1);
        check("train_tx0", 32'(tx), 32'(CN));
        check("train_mac_en", 32'(mac_en), 32'd1);
      end
      if (n == 2) check("train_tx1", 32'(tx), 32'(TS));
      if (inv && n == 5) check("pol_before_flip", 32'(pol), 32'd0);
      if (inv && n == 6) check("pol_after_flip", 32'(pol), 32'd1);
      if (n == lock_at - 1) check("link_up_early", 32'(link_up), 32'd0);
      if (n == lock_at) begin
        check("lock_link_up", 32'(link_up), 32'd1);
        check("lock_state", 32'(state), 32'd2);
        check("lock_ready", 32'(ready), 32'd1);
        check("lock_pol", 32'(pol), 32'(inv));
        check("lock_tx_fill", 32'(tx), 32'(CN));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    link_en   = 1'b0;
    retrain   = 1'b0;
    mac_data  = '0;
    mac_valid = 1'b0;
    rx        = '0;
    loop_on   = 1'b0;
    loop_inv  = 1'b0;
    dl0       = '0;
    dl1       = '0;
    dl2       = '0;

    #12;
    check("rst_tx", 32'(tx), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_pol", 32'(pol), 32'd0);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_state", 32'(state), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_state", 32'(state), 32'd0);

    // Normal polarity loopback, then MAC pass-through and idle fill.
    run_lock(1'b0);
    tick();
    check("idle_fill", 32'(tx), 32'(CN));
    mac_valid = 1'b1;
    mac_data  = 10'h17C;
    tick();
    check("mac_pass", 32'(tx), 32'h17C);
    mac_valid = 1'b0;
    tick();
    check("idle_fill2", 32'(tx), 32'(CN));
    check("up_state", 32'(state), 32'd2);

    // Retrain pulse from LINK_UP.
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    check("rt_state", 32'(state), 32'd1);
    check("rt_link_up", 32'(link_up), 32'd0);
    check("rt_ready", 32'(ready), 32'd0);
    check("rt_tx", 32'(tx), 32'(CN));
    check("rt_mac_en", 32'(mac_en), 32'd1);
`ifdef PMA_LINK_STATS_EN
    check("rc_after_retrain", 32'(rc), 32'd1);
`endif

    link_en = 1'b0;
    tick();
    check("dis_state", 32'(state), 32'd0);
    check("dis_mac_en", 32'(mac_en), 32'd0);
    check("dis_tx", 32'(tx), 32'd0);

    // Inverted lane: one polarity flip, then lock.
    run_lock(1'b1);

    // Retrain together with Link_En = 0: disable wins.
    retrain = 1'b1;
    link_en = 1'b0;
    tick();
    retrain = 1'b0;
    check("rtdis_state", 32'(state), 32'd0);
    check("rtdis_mac_en", 32'(mac_en), 32'd0);
    check("rtdis_link_up", 32'(link_up), 32'd0);
    check("rtdis_pol", 32'(pol), 32'd0);
`ifdef PMA_LINK_STATS_EN
    check("rc_after_disable", 32'(rc), 32'd1);
`endif

    // Loss of sync: no commas for LosCnt cycles in LINK_UP.
    run_lock(1'b1);
    loop_on = 1'b0;
    rx      = '0;
    for (int n = 1; n <= 255; n++) tick();
    check("los_hold_state", 32'(state), 32'd2);
    check("los_hold_link", 32'(link_up), 32'd1);
    tick();
    check("los_state", 32'(state), 32'd1);
    check("los_link_up", 32'(link_up), 32'd0);
    check("los_ready", 32'(ready), 32'd0);
    check("los_pol", 32'(pol), 32'd0);
`ifdef PMA_LINK_STATS_EN
    check("rc_after_los", 32'(rc), 32'd2);
`endif

    // RX stuck at zero: training timeouts every TrainTimeout cycles.
    for (int m = 1; m <= 2048; m++) begin
      tick();
      if (m == 1023 || m == 2047) check("fail_early", 32'(fail), 32'd0);
      if (m == 1024 || m == 2048) begin
        check("fail_pulse", 32'(fail), 32'd1);
        check("fail_link_up", 32'(link_up), 32'd0);
        check("fail_pol", 32'(pol), 32'd0);
        check("fail_state", 32'(state), 32'd1);
      end
      if (m == 1025) check("fail_one_cycle", 32'(fail), 32'd0);
    end
`ifdef PMA_LINK_STATS_EN
    check("rc_after_fails", 32'(rc), 32'd4);
`endif

    // Async reset mid-TRAIN, checked before any further clock edge.
    tick();
    check("pre_rst_mac_en", 32'(mac_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd0);
    check("arst_mac_en", 32'(mac_en), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_link_up", 32'(link_up), 32'd0);
    check("arst_fail", 32'(fail), 32'd0);
`ifdef PMA_LINK_STATS_EN
    check("arst_rc", 32'(rc), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
